iter_sequencer: RTL and testbench

- Loadable down-counting iteration sequencer for the multdiv datapath.
- Accepts a start request with an iteration count and emits one step strobe per active cycle, plus first/last flags, until the count reaches 0.
- Signals completion with a one-cycle done pulse.
- Replaces free-running up-counters plus external terminal-count compares in the multiplier/divider control path.

---
 rtl/iter_sequencer_if.sv | 39 +++
 rtl/iter_sequencer.sv | 101 ++++++++++
 tb/tb_iter_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/iter_sequencer_if.sv
// Handshake and status bundle for iter_sequencer.
// Build option: ITER_SEQ_ABORT_EN adds the abort request line.
// Signals:
//   start, load_val, stall (abort) - requester to sequencer
//   ready, busy, step, first, last, count, done - sequencer to requester
// Modports: master (requester side), slave (sequencer side).
interface iter_sequencer_if #(
    parameter int unsigned WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             stall;
`ifdef ITER_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             busy;
    logic             step;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] count;
    logic             done;

    modport master (
        output start, load_val, stall,
`ifdef ITER_SEQ_ABORT_EN
        output abort,
`endif
        input  ready, busy, step, first, last, count, done
    );

    modport slave (
        input  start, load_val, stall,
`ifdef ITER_SEQ_ABORT_EN
        input  abort,
`endif
        output ready, busy, step, first, last, count, done
    );
endinterface

// File: rtl/iter_sequencer.sv
// Loadable down-counting iteration sequencer for the multdiv datapath.
// A start accepted while ready loads min(load_val, MAX_COUNT); one step strobe is
// issued per unstalled RUN cycle with first/last flags, then done pulses for one cycle.
// Build option: ITER_SEQ_ABORT_EN adds bus.abort, which returns RUN/DONE to IDLE
// with no done pulse.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous reset, active-low
//   bus - iter_sequencer_if slave modport (start/load_val/stall in, status out)
module iter_sequencer #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_COUNT = 32
) (
    input  logic               clk,
    input  logic               rst,
    iter_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] MaxCountW = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] OneW      = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             first_pend_q, first_pend_d;

    logic [WIDTH-1:0] load_clamped;
    logic             abort_req;
    logic             step_int;

    assign load_clamped = (bus.load_val > MaxCountW) ? MaxCountW : bus.load_val;

`ifdef ITER_SEQ_ABORT_EN
    // Abort only matters once a sequence has been accepted.
    assign abort_req = bus.abort && (state_q != StIdle);
`else
    assign abort_req = 1'b0;
`endif

    assign step_int = (state_q == StRun) && !bus.stall && !abort_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            count_q      <= '0;
            first_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            first_pend_q <= first_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        first_pend_d = first_pend_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    count_d      = load_clamped;
                    first_pend_d = (load_clamped != '0);
                    // Zero-iteration request goes straight to DONE.
                    state_d      = (load_clamped != '0) ? StRun : StDone;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (step_int) begin
                    count_d      = count_q - OneW;
                    first_pend_d = 1'b0;
                    if (count_q == OneW) begin
                        state_d = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase

        if (abort_req) begin
            state_d      = StIdle;
            count_d      = '0;
            first_pend_d = 1'b0;
        end
    end

    always_comb begin
        bus.ready = (state_q == StIdle) || (state_q == StDone);
        bus.busy  = (state_q == StRun);
        bus.step  = step_int;
        bus.first = step_int && first_pend_q;
        bus.last  = step_int && (count_q == OneW);
        bus.count = count_q;
        bus.done  = (state_q == StDone);
    end
endmodule

// File: tb/tb_iter_sequencer.sv
module tb_iter_sequencer;
    localparam int unsigned W  = 6;
    localparam int unsigned MC = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iter_sequencer_if #(.WIDTH(W)) bus ();

    iter_sequencer #(.WIDTH(W), .MAX_COUNT(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: a sequence is "active" exactly while iterations remain.
    int m_rem   = 0;
    int m_taken = 0;
    bit m_done  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit stall);
        bit e_busy, e_step;
        e_busy = (m_rem != 0);
        e_step = e_busy && !stall;
        check_eq("count", 32'(bus.count), 32'(m_rem));
        check_eq("busy", 32'(bus.busy), 32'(e_busy));
        check_eq("ready", 32'(bus.ready), 32'(!e_busy));
        check_eq("step", 32'(bus.step), 32'(e_step));
        check_eq("first", 32'(bus.first), 32'(e_step && m_taken == 0));
        check_eq("last", 32'(bus.last), 32'(e_step && m_rem == 1));
        check_eq("done", 32'(bus.done), 32'(m_done));
    endtask

    task automatic model_advance(input bit start, input int lv, input bit stall);
        if (m_rem == 0 && start) begin
            m_rem   = (lv > MC) ? MC : lv;
            m_taken = 0;
            m_done  = (m_rem == 0);
        end else begin
            m_done = 0;
            if (m_rem != 0 && !stall) begin
                m_rem--;
                m_taken++;
                if (m_rem == 0) m_done = 1;
            end
        end
    endtask

    task automatic cyc(input bit start, input int lv, input bit stall);
        @(negedge clk);
        bus.start    = start;
        bus.load_val = W'(lv);
        bus.stall    = stall;
        #1;
        check_outputs(stall);
        model_advance(start, lv, stall);
        @(posedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.load_val = '0;
        bus.stall    = 1'b0;
`ifdef ITER_SEQ_ABORT_EN
        bus.abort    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Five iterations, no stalls, then idle until ready.
        cyc(1, 5, 0);
        repeat (7) cyc(0, 0, 0);
        // Three iterations with stalls on the first and third active cycles.
        cyc(1, 3, 0);
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
        repeat (2) cyc(0, 0, 0);
        // Zero-iteration and single-iteration sequences.
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        // Clamp to MAX_COUNT, start ignored in RUN, restart in DONE cycle.
        cyc(1, 40, 0);
        for (int i = 0; i < 32; i++) cyc((i % 5) == 2, 7, 0);
        cyc(1, 2, 0);
        repeat (4) cyc(0, 0, 0);

        // Asynchronous reset mid-sequence at count 7.
        cyc(1, 10, 0);
        repeat (3) cyc(0, 0, 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        #1;
        check_eq("pre_rst_count", 32'(bus.count), 32'd7);
        #1;
        rst = 1'b0;
        #1;
        m_rem = 0; m_taken = 0; m_done = 0;
        check_outputs(1'b0);
        @(posedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 2, 0);
        repeat (4) cyc(0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) == 0, int'($urandom_range(0, 63)), ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
